// File: rtl/mdu_pkg.sv
// mdu_pkg: operation and FSM state types shared by the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} op_t;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;
  function automatic logic is_signed(op_t o);
    return !o[0];
  endfunction
endpackage

// File: rtl/mdu_abs.sv
// mdu_abs: combinational magnitude of x when en and x is negative
//   en  : treat x as signed
//   x   : operand
//   y   : |x| if en & x[WIDTH-1], else x
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = en && x[WIDTH-1] ? -x : x;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU)
//   clk, reset        : rising-edge clock, async active-high reset
//   start, op, a, b   : request, sampled while busy=0
//   busy, done        : in-flight flag, one-cycle completion pulse
//   div_by_zero, hi, lo : results, updated only when done rises
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, next_state;
  op_t op_q;
  logic [WIDTH-1:0] a_q, b_q, a_mag, b_mag, ddiff, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] msum, dpart;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, sgn, dbit, dz;
  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.en(sgn), .x(a_q), .y(a_mag));
  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.en(sgn), .x(b_q), .y(b_mag));
  assign busy = state != S_IDLE;
  assign sgn = is_signed(op_q);
  // multiply step: add multiplier into the top half, shift the 2W+1 result right
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? b_q : WIDTH'(0)};
  // divide step: partial remainder shifted left with the next dividend bit
  assign dpart = acc[2*WIDTH-1:WIDTH-1];
  assign dbit = dpart >= {1'b0, b_q};
  assign ddiff = dbit ? dpart[WIDTH-1:0] - b_q : dpart[WIDTH-1:0];
  assign prod = sgn && sign_q ? -acc : acc;
  assign quo = sgn && sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = sgn && sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // b_q holds |b| by FIX, which is zero exactly when b was zero
  assign dz = op_q[1] && b_q == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: next_state = start ? S_PREP : S_IDLE;
      S_PREP: next_state = S_RUN;
      S_RUN:  next_state = cnt == '0 ? S_FIX : S_RUN;
      S_FIX:  next_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= MDU_MULT;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          op_q <= op;
          a_q <= a;
          b_q <= b;
        end
        S_PREP: begin
          a_q <= a_mag;
          b_q <= b_mag;
          sign_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= sgn & a_q[WIDTH-1];
          cnt <= CW'(WIDTH-1);
          acc <= {{WIDTH{1'b0}}, a_mag};
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          acc <= op_q[1] ? {ddiff, acc[WIDTH-2:0], dbit} : {msum, acc[WIDTH-1:1]};
        end
        S_FIX: begin
          done <= 1'b1;
          div_by_zero <= dz;
          hi <= op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
          lo <= dz ? '1 : op_q[1] ? quo : prod[WIDTH-1:0];
        end
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table, random and sequence checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  import mdu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  op_t op = MDU_MULT;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done, div_by_zero;
  int checks = 0, failures = 0;
  typedef struct {
    op_t op;
    logic [31:0] a, b, hi, lo;
    logic dz;
  } vec_t;
  vec_t vecs[10];
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  function automatic void model(input op_t o, input logic [31:0] x, y,
                                output logic [31:0] h, l, output logic z);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] p;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      MDU_MULT: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      MDU_MULTU: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      MDU_DIV: if (y == 0) begin z = 1'b1; h = x; l = '1; end
               else begin l = 32'(sx / sy); h = 32'(sx % sy); end
      MDU_DIVU: if (y == 0) begin z = 1'b1; h = x; l = '1; end
                else begin l = x / y; h = x % y; end
    endcase
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic launch(input op_t o, input logic [31:0] x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 60) begin @(posedge clk); #1; n++; end
  endtask
  task automatic run(input string nm, input op_t o, input logic [31:0] x, y, eh, el, input logic ez);
    int n;
    @(negedge clk);
    launch(o, x, y);
    chk({nm, " busy_rise"}, busy, 1);
    wait_done(0, n);
    chk({nm, " latency"}, n, 34);
    chk({nm, " busy_at_done"}, busy, 0);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " dz"}, div_by_zero, ez);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] eh, el, x, y;
    logic ez;
    op_t o;
    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[3] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[5] = '{MDU_DIVU,  32'd6,        32'd6,        32'd0,        32'd1,        1'b0};
    vecs[6] = '{MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[7] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[8] = '{MDU_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dz", div_by_zero, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
    run("div 7/-2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    for (int i = 0; i < 40; i++) begin
      o = op_t'($urandom_range(0, 3));
      x = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      y = $urandom_range(0, 6) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      model(o, x, y, eh, el, ez);
      run($sformatf("rand%0d", i), o, x, y, eh, el, ez);
    end
    @(negedge clk);
    launch(MDU_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n);
    chk("ignored start latency", n, 34);
    chk("ignored start hi", hi, 0);
    chk("ignored start lo", lo, 12);
    launch(MDU_DIVU, 32'd100, 32'd7);
    chk("b2b accepted busy", busy, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold lo while busy", lo, 12);
    wait_done(5, n);
    chk("b2b latency", n, 34);
    chk("b2b hi", hi, 2);
    chk("b2b lo", lo, 14);
    @(negedge clk);
    launch(MDU_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    #3 reset = 1'b0;
    n = 0;
    repeat (50) begin @(posedge clk); #1; if (done) n++; end
    chk("no done after abort", n, 0);
    run("post-reset div", MDU_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
